// File: rtl/rptr_empty.sv
// Read-side pointer and empty/almost-empty logic for an asynchronous FIFO.
// Tracks the read pointer in binary and Gray code and derives occupancy from the synchronized write pointer.
module rptr_empty #(
  parameter int ASIZE        = 4,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             rclr_uf,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AEMPTY_LEVEL);

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] rlevel_q, rlevel_d;
  logic [ASIZE:0] wbin_s;
  logic           rempty_q, rempty_d;
  logic           arempty_q, arempty_d;
  logic           ruf_q, ruf_d;
  logic           pop;

  always_comb begin
    pop       = rinc & ~rempty_q;
    rbin_d    = rbin_q + {{ASIZE{1'b0}}, pop};
    rptr_d    = (rbin_d >> 1) ^ rbin_d;
    wbin_s    = gray2bin(rq2_wptr);
    rlevel_d  = wbin_s - rbin_d;
    rempty_d  = (rptr_d == rq2_wptr);
    arempty_d = (rlevel_d <= AE_LVL);
    // A failed read in the same cycle outranks a clear request.
    if (rinc && rempty_q)
      ruf_d = 1'b1;
    else if (rclr_uf)
      ruf_d = 1'b0;
    else
      ruf_d = ruf_q;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      ruf_q     <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      arempty_q <= arempty_d;
      ruf_q     <= ruf_d;
    end
  end

  assign raddr      = rbin_q[ASIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign arempty    = arempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = ruf_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: directed phases plus a randomized stream, checked
// against an occupancy-counting model of the FIFO read side.
module tb_rptr_empty;

  localparam int ASIZE = 4;
  localparam int AE    = 1;
  localparam int DEPTH = 1 << ASIZE;
  localparam int PMOD  = 2 * DEPTH;

  logic             rclk = 1'b0;
  logic             rrst = 1'b0;
  logic             rinc = 1'b0;
  logic [ASIZE:0]   rq2_wptr = '0;
  logic             rclr_uf = 1'b0;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic             arempty;
  logic [ASIZE:0]   rlevel;
  logic             runderflow;

  bit clk_en = 1'b0;
  always #5 if (clk_en) rclk = ~rclk;

  rptr_empty #(.ASIZE(ASIZE), .AEMPTY_LEVEL(AE)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rclr_uf(rclr_uf), .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .arempty(arempty), .rlevel(rlevel), .runderflow(runderflow)
  );

  int tests = 0;
  int errs  = 0;

  // Model state: total entries written / read as plain counts.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_ae = 1'b1;
  bit m_uf = 1'b0;
  int q[$];
  int next_id = 0;

  function automatic logic [ASIZE:0] to_gray(input int n);
    logic [ASIZE:0] v;
    v = (ASIZE+1)'(n % PMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".rptr"},    32'(rptr),       32'(to_gray(rd_cnt)));
    check({ph, ".raddr"},   32'(raddr),      32'(rd_cnt % DEPTH));
    check({ph, ".rempty"},  32'(rempty),     32'(m_empty));
    check({ph, ".arempty"}, 32'(arempty),    32'(m_ae));
    check({ph, ".rlevel"},  32'(rlevel),     32'(m_level));
    check({ph, ".ruf"},     32'(runderflow), 32'(m_uf));
  endtask

  task automatic model_reset();
    rd_cnt = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
    q.delete();
  endtask

  task automatic set_wr(input int n);
    while (wr_cnt < n) begin
      q.push_back(next_id);
      next_id++;
      wr_cnt++;
    end
    wr_cnt = n;
    rq2_wptr = to_gray(wr_cnt);
  endtask

  // One rclk edge: check the entry being read, advance the model, check outputs.
  task automatic tick(input string ph);
    bit pop;
    pop = rinc && !m_empty;
    if (pop) begin
      check({ph, ".entry"}, 32'(raddr), 32'(q.size() > 0 ? q[0] % DEPTH : -1));
      if (q.size() > 0) void'(q.pop_front());
    end
    @(posedge rclk);
    if (rinc && m_empty) m_uf = 1;
    else if (rclr_uf) m_uf = 0;
    if (pop) rd_cnt++;
    m_level = wr_cnt - rd_cnt;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
    #1;
    check_all(ph);
  endtask

  initial begin
    int wrote, popped, occ;
    bit saw_pwrap, saw_awrap;
    logic [ASIZE:0] prev_rptr;
    logic [ASIZE-1:0] prev_raddr;

    // Reset with the clock stopped.
    rrst = 1'b1;
    #3;
    model_reset();
    check_all("reset");
    check("reset.rptr0", 32'(rptr), 32'h0);

    clk_en = 1'b1;
    rinc = 1'b1; rclr_uf = 1'b1;
    @(posedge rclk); #1;
    check_all("inrst");
    @(negedge rclk);
    rrst = 1'b0; rinc = 1'b0; rclr_uf = 1'b0;
    tick("idle");

    // Fill with 3 then drain.
    set_wr(3);
    tick("fill");
    check("fill.lvl3", 32'(rlevel), 32'd3);
    rinc = 1'b1;
    tick("pop1");
    tick("pop2");
    check("pop2.lvl1", 32'(rlevel), 32'd1);
    check("pop2.ae", 32'(arempty), 32'd1);
    tick("pop3");
    check("pop3.empty", 32'(rempty), 32'd1);
    check("pop3.raddr", 32'(raddr), 32'd3);
    check("pop3.rptr", 32'(rptr), 32'b00010);

    // Underflow set / clear / priority.
    tick("uf_set");
    check("uf_set.flag", 32'(runderflow), 32'd1);
    check("uf_set.rptr", 32'(rptr), 32'b00010);
    rinc = 1'b0; rclr_uf = 1'b1;
    tick("uf_clr");
    check("uf_clr.flag", 32'(runderflow), 32'd0);
    rinc = 1'b1;
    tick("uf_both");
    check("uf_both.flag", 32'(runderflow), 32'd1);
    rinc = 1'b0;
    tick("uf_clr2");

    // Randomized stream of 40 entries across the pointer wrap.
    wrote = 0; popped = 0; saw_pwrap = 0; saw_awrap = 0;
    for (int cyc = 0; cyc < 3000 && popped < 40; cyc++) begin
      occ = wr_cnt - rd_cnt;
      if (wrote < 40 && occ < DEPTH && $urandom_range(0, 1) == 1) begin
        set_wr(wr_cnt + 1);
        wrote++;
      end
      rinc = ($urandom_range(0, 2) != 0);
      rclr_uf = ($urandom_range(0, 3) == 0);
      if (rinc && !m_empty) popped++;
      prev_rptr = rptr; prev_raddr = raddr;
      tick("stream");
      if (prev_rptr == 5'b10000 && rptr == 5'b00000) saw_pwrap = 1;
      if (prev_raddr == 4'd15 && raddr == 4'd0) saw_awrap = 1;
    end
    rinc = 1'b0; rclr_uf = 1'b0;
    check("stream.popped", 32'(popped), 32'd40);
    check("stream.qleft", 32'(q.size()), 32'd0);
    check("stream.pwrap", 32'(saw_pwrap), 32'd1);
    check("stream.awrap", 32'(saw_awrap), 32'd1);

    // Full FIFO from a fresh reset.
    @(negedge rclk);
    rrst = 1'b1; wr_cnt = 0; rq2_wptr = '0; next_id = 0;
    #1; model_reset(); check_all("rst2");
    @(negedge rclk); rrst = 1'b0;
    set_wr(DEPTH);
    check("full.wptr", 32'(rq2_wptr), 32'b11000);
    tick("full");
    check("full.lvl", 32'(rlevel), 32'd16);
    check("full.empty", 32'(rempty), 32'd0);
    check("full.ae", 32'(arempty), 32'd0);
    rinc = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick("drain");
    check("drain.empty", 32'(rempty), 32'd1);
    rinc = 1'b0;

    // Reset in the middle of operation.
    set_wr(wr_cnt + 5);
    tick("mid");
    check("mid.lvl5", 32'(rlevel), 32'd5);
    rinc = 1'b1;
    #2;
    rrst = 1'b1;
    #1;
    model_reset(); wr_cnt = 0; next_id = 0;
    check_all("midrst");
    rq2_wptr = '0;
    @(negedge rclk);
    rrst = 1'b0; rinc = 1'b0;
    tick("post1");
    rinc = 1'b1;
    tick("post2");
    check("post2.empty", 32'(rempty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
